mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the data-memory side of the pipeline CPU. Consumes the store traffic that leaves the EX/MEM register (address, store value, write enable) and queues bytes in a small FIFO. Serialises the queued bytes as 8N1 frames on a single output pin, and returns a status word on loads to its address window. It is the first I/O peripheral downstream of the MEM stage and lets test programs print results.

---
 rtl/mmio_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to TXDATA queue bytes in a small FIFO,
// loads from STATUS return fifo/FSM/overflow state. Window is two words at BASE_ADDR.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [29:0]   TXDATA_WORD = BASE_ADDR[31:2];
  localparam logic [29:0]   STATUS_WORD = BASE_ADDR[31:2] + 30'd1;
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          overflow_reg;

  state_t        state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;

  logic          hit_txdata, hit_status;
  logic          push_req, push, pop;
  logic          fifo_full, fifo_empty, ovf_clear, baud_done;
  logic [31:0]   status;
  logic          unused_bits;

  assign hit_txdata = (mem_addr[31:2] == TXDATA_WORD);
  assign hit_status = (mem_addr[31:2] == STATUS_WORD);
  assign fifo_full  = (count_reg == DEPTH_C);
  assign fifo_empty = (count_reg == '0);

  // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a push.
  assign push_req  = mem_we & hit_txdata;
  assign push      = push_req & ~fifo_full;
  assign ovf_clear = mem_we & hit_status & mem_wdata[3];

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= mem_wdata[7:0];
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      // A new overflow wins over a same-cycle clear.
      if (push_req && fifo_full) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clear) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign baud_done = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr_reg];
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Chain straight into the next start bit when more bytes are queued.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr_reg];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    status          = '0;
    status[0]       = fifo_full;
    status[1]       = fifo_empty;
    status[2]       = (state_reg != IDLE);
    status[3]       = overflow_reg;
    status[8 +: CW] = count_reg;
  end

  assign mem_rdata = (mem_re && hit_status) ? status : 32'h0;
  assign tx        = tx_reg;
  assign busy      = !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8): line waveform,
// STATUS word, overflow, mid-frame reset and address decode, with a line receiver model.
module tb_mmio_uart_tx;

  localparam int          CPB  = 4;
  localparam int          FLEN = 10 * CPB;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [31:0] mem_rdata;
  logic        tx;
  logic        busy;

  int vec_count = 0;
  int miscompare_count = 0;

  logic [7:0]  exp_bytes [16];
  logic [7:0]  rx_q [$];
  int          rx_k = -1;
  logic        rx_prev = 1'b1;
  logic [7:0]  rx_shift = '0;
  int          rx_frame_err = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (8),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .tx       (tx),
    .busy     (busy)
  );

  // Receiver: detect falling start edge, sample each bit mid-cell.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      rx_k    = -1;
      rx_prev = 1'b1;
    end else begin
      if (rx_k < 0) begin
        if (rx_prev && !tx) rx_k = 0;
      end else begin
        rx_k++;
      end
      if (rx_k >= CPB && rx_k < 9 * CPB && (rx_k % CPB) == CPB / 2)
        rx_shift = {tx, rx_shift[7:1]};
      if (rx_k == 9 * CPB + CPB / 2) begin
        rx_q.push_back(rx_shift);
        if (!tx) rx_frame_err++;
        rx_k = -1;
      end
      rx_prev = tx;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompare_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    mem_addr  = addr;
    mem_wdata = data;
    mem_we    = 1'b1;
    $display("write addr=%h data=%h", addr, data);
    step();
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    mem_addr = addr;
    mem_re   = 1'b1;
    #1;
    data     = mem_rdata;
    mem_re   = 1'b0;
    mem_addr = '0;
    $display("read  addr=%h data=%h", addr, data);
  endtask

  // Checks tx every cycle against n contiguous 8N1 frames of exp_bytes.
  task automatic watch_frames(input int n, input string tag);
    for (int i = 0; i < n * FLEN; i++) begin
      int   f;
      int   p;
      logic e;
      f = i / FLEN;
      p = (i % FLEN) / CPB;
      if (p == 0)      e = 1'b0;
      else if (p == 9) e = 1'b1;
      else             e = exp_bytes[f][p-1];
      check($sformatf("%s_f%0d_c%0d", tag, f, i), 32'(tx), 32'(e));
      if (i < n * FLEN - 1) step();
    end
  endtask

  task automatic check_rx(input int n, input string tag);
    logic [31:0] got;
    check($sformatf("%s_rx_count", tag), 32'(rx_q.size()), 32'(n));
    for (int j = 0; j < n; j++) begin
      if (j < rx_q.size()) got = 32'(rx_q[j]);
      else                 got = 32'hDEAD;
      check($sformatf("%s_rx%0d", tag, j), got, 32'(exp_bytes[j]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          n;

    // Reset then idle
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    bus_read(BASE + 32'd4, rd);
    check("rst_status", rd, 32'h0000_0002);
    mem_addr = BASE + 32'd4;
    #1;
    check("status_no_re", mem_rdata, 32'h0);
    mem_addr = '0;

    // Single byte: start bit begins two edges after the write edge
    rx_q.delete();
    exp_bytes[0] = 8'hA5;
    bus_write(BASE, 32'h0000_00A5);
    check("a5_busy_rise", 32'(busy), 32'd1);
    step();
    check("a5_line_pre", 32'(tx), 32'd1);
    step();
    watch_frames(1, "a5");
    check("a5_busy_fall", 32'(busy), 32'd0);
    check_rx(1, "a5");

    // Back-to-back frames, no idle gap
    step();
    rx_q.delete();
    exp_bytes[0] = 8'h55;
    exp_bytes[1] = 8'h0F;
    bus_write(BASE, 32'h55);
    bus_write(BASE, 32'h0F);
    check("b2b_line_pre", 32'(tx), 32'd1);
    step();
    bus_read(BASE + 32'd4, rd);
    check("b2b_status", rd, 32'h0000_0104);
    watch_frames(2, "b2b");
    check("b2b_busy_fall", 32'(busy), 32'd0);
    check_rx(2, "b2b");

    // Overflow: one popped, eight held, tenth dropped
    step();
    rx_q.delete();
    for (int j = 0; j < 9; j++) begin
      exp_bytes[j] = 8'(8'h10 + j);
      bus_write(BASE, 32'(32'h10 + j));
    end
    bus_read(BASE + 32'd4, rd);
    check("ovf_full", rd, 32'h0000_0805);
    bus_write(BASE, 32'h19);
    bus_read(BASE + 32'd4, rd);
    check("ovf_set", rd, 32'h0000_080D);
    bus_write(BASE + 32'd4, 32'h8);
    bus_read(BASE + 32'd4, rd);
    check("ovf_clear", rd, 32'h0000_0805);
    n = 0;
    while (busy && n < 600) begin
      step();
      n++;
    end
    check("ovf_drain_cycles", 32'(n), 32'd351);
    bus_read(BASE + 32'd4, rd);
    check("ovf_final_status", rd, 32'h0000_0002);
    check_rx(9, "ovf");

    // Reset during DATA bit 3
    step();
    rx_q.delete();
    bus_write(BASE, 32'hC3);
    repeat (19) step();
    check("mid_bit3", 32'(tx), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    bus_read(BASE + 32'd4, rd);
    check("mid_rst_status", rd, 32'h0000_0002);
    for (int j = 0; j < 50; j++) begin
      step();
      check($sformatf("mid_idle_c%0d", j), 32'(tx), 32'd1);
    end
    check("mid_rx_none", 32'(rx_q.size()), 32'd0);

    // Decode: off-window store, non-clear STATUS store, loads
    bus_write(BASE + 32'd8, 32'hAA);
    bus_write(BASE + 32'd4, 32'hF7);
    bus_read(BASE, rd);
    check("dec_txdata_load", rd, 32'h0);
    bus_read(BASE + 32'd8, rd);
    check("dec_off_load", rd, 32'h0);
    bus_read(BASE + 32'd6, rd);
    check("dec_status_lowbits", rd, 32'h0000_0002);
    repeat (12) step();
    check("dec_tx_idle", 32'(tx), 32'd1);
    check("dec_busy", 32'(busy), 32'd0);
    check("rx_stop_bits", 32'(rx_frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
    $finish;
  end

endmodule
